// File: rtl/interp_pkg.sv
// Shared types and constants for the 3-phase polyphase interpolator.
// Coefficient tables are indexed by window position (index 0 = newest sample).
package interp_pkg;

  typedef enum logic [1:0] {
    PH_A = 2'd0,
    PH_B = 2'd1,
    PH_C = 2'd2
  } phase_t;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_IDLE = 2'd1,
    ST_LOAD = 2'd2,
    ST_EMIT = 2'd3
  } state_t;

  localparam int TAPS       = 6;
  localparam int PRIME_N    = 6;
  localparam int NORM_SHIFT = 6;
  localparam int NORM_ROUND = 32;

  // Listed w0..w5; each phase's taps sum to 64 (B to 66).
  localparam int COEF_A [TAPS] = '{0, -5, 17, 58, -10, 4};
  localparam int COEF_B [TAPS] = '{4, -11, 40, 40, -11, 4};
  localparam int COEF_C [TAPS] = '{0, 4, -10, 58, 17, -5};

  function automatic int coef(input phase_t ph, input int idx);
    case (ph)
      PH_A:    return COEF_A[idx];
      PH_B:    return COEF_B[idx];
      default: return COEF_C[idx];
    endcase
  endfunction

endpackage

// File: rtl/interp_mac.sv
// Combinational 6-tap multiply-accumulate for one interpolator phase.
// INTERP_NORMALISE_EN: output is the rounded sum shifted right by NORM_SHIFT.
module interp_mac
  import interp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ACC_W  = DATA_W + 8
) (
  input  logic [TAPS-1:0][DATA_W-1:0] win,
  input  phase_t                      phase,
  output logic [ACC_W-1:0]            sum
);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] cf;

  // Sum wraps modulo 2^ACC_W; no saturation.
  always_comb begin
    acc = '0;
    ext = '0;
    cf  = '0;
    for (int i = 0; i < TAPS; i++) begin
      ext = {{(ACC_W-DATA_W){win[i][DATA_W-1]}}, win[i]};
      cf  = ACC_W'(coef(phase, i));
      acc = acc + ext * cf;
    end
  end

`ifdef INTERP_NORMALISE_EN
  logic signed [ACC_W-1:0] rnd;
  assign rnd = acc + ACC_W'(NORM_ROUND);
  assign sum = rnd >>> NORM_SHIFT;
`else
  assign sum = acc;
`endif

endmodule

// File: rtl/interp_stream.sv
// Streaming 3-phase polyphase interpolator with valid/ready flow control.
// Optional output normalisation selected by INTERP_NORMALISE_EN (see interp_mac).
//
// state | meaning
// FILL  | priming the window, accepting samples, no output
// IDLE  | primed, waiting for the next sample
// LOAD  | register phase A result for the newest window
// EMIT  | present out_data; advance A->B->C on out_ready
module interp_stream
  import interp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ACC_W  = DATA_W + 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [1:0]        out_phase
);

  state_t                      state_q, state_d;
  logic [TAPS-1:0][DATA_W-1:0] win_q;
  logic [2:0]                  cnt_q;
  phase_t                      phase_q, phase_d;
  logic [ACC_W-1:0]            data_q;
  logic                        shift_en;
  logic                        load_en;
  phase_t                      mac_phase;
  logic [ACC_W-1:0]            mac_sum;

  interp_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .win   (win_q),
    .phase (mac_phase),
    .sum   (mac_sum)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    shift_en  = 1'b0;
    load_en   = 1'b0;
    mac_phase = PH_A;
    phase_d   = phase_q;
    case (state_q)
      ST_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift_en = 1'b1;
          if (cnt_q == 3'(PRIME_N - 1)) state_d = ST_LOAD;
        end
      end
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift_en = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_en   = 1'b1;
        mac_phase = PH_A;
        phase_d   = PH_A;
        state_d   = ST_EMIT;
      end
      ST_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          case (phase_q)
            PH_A: begin
              load_en   = 1'b1;
              mac_phase = PH_B;
              phase_d   = PH_B;
            end
            PH_B: begin
              load_en   = 1'b1;
              mac_phase = PH_C;
              phase_d   = PH_C;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      default: state_d = ST_FILL;
    endcase
    // Flush discards any handshake or phase advance in the same cycle.
    if (flush) state_d = ST_FILL;
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_FILL;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      win_q   <= '0;
      cnt_q   <= '0;
      phase_q <= PH_A;
      data_q  <= '0;
    end else if (flush) begin
      win_q <= '0;
      cnt_q <= '0;
    end else begin
      if (shift_en) begin
        win_q <= {win_q[TAPS-2:0], in_data};
        if (state_q == ST_FILL) cnt_q <= cnt_q + 3'd1;
      end
      if (load_en) begin
        data_q  <= mac_sum;
        phase_q <= phase_d;
      end
    end
  end

  assign out_data  = data_q;
  assign out_phase = phase_q;

endmodule

// File: tb/tb_interp_stream.sv
// Directed testbench for interp_stream: table of sample/expected-triple vectors
// plus hand sequences for back-pressure, flush and mid-burst reset.
module tb_interp_stream;

  localparam int DATA_W = 32;
  localparam int ACC_W  = DATA_W + 8;

`ifdef INTERP_NORMALISE_EN
  localparam longint R_A = 3,   R_B = 4,   R_C = 3;
  localparam longint K_A = 100, K_B = 103, K_C = 100;
  localparam longint N_A = -1,  N_B = -1,  N_C = -1;
`else
  localparam longint R_A = 201,  R_B = 231,  R_C = 183;
  localparam longint K_A = 6400, K_B = 6600, K_C = 6400;
  localparam longint N_A = -64,  N_B = -66,  N_C = -64;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ACC_W-1:0]  out_data;
  logic [1:0]        out_phase;

  int checks   = 0;
  int failures = 0;

  interp_stream #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_phase (out_phase)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit     clr;
    int     din;
    bit     has_out;
    longint ea, eb, ec;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic push(input int d);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("in_ready_wait", longint'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = DATA_W'(d);
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic chk_out(input string name, input longint exp, input int ph);
    chk({name, "_valid"}, longint'(out_valid), 1);
    chk({name, "_ready_low"}, longint'(in_ready), 0);
    chk({name, "_data"}, longint'($signed(out_data)), exp);
    chk({name, "_phase"}, longint'(out_phase), ph);
  endtask

  // Push one sample with out_ready=1 and check exact-cycle output behaviour.
  task automatic push_check(input int d, input bit has_out,
                            input longint ea, input longint eb, input longint ec);
    push(d);
    @(negedge clock);
    chk("post_push_valid", longint'(out_valid), 0);
    if (has_out) begin
      chk("load_ready", longint'(in_ready), 0);
      @(negedge clock); chk_out("ph_a", ea, 0);
      @(negedge clock); chk_out("ph_b", eb, 1);
      @(negedge clock); chk_out("ph_c", ec, 2);
      @(negedge clock);
      chk("idle_valid", longint'(out_valid), 0);
      chk("idle_ready", longint'(in_ready), 1);
    end else begin
      chk("fill_ready", longint'(in_ready), 1);
    end
  endtask

  task automatic prime5();
    for (int i = 1; i <= 5; i++) push_check(i, 1'b0, 0, 0, 0);
    push(6);
    @(negedge clock);
    @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 1; i <= 6; i++)
      vecs.push_back('{i == 1, i, i == 6, R_A, R_B, R_C});
    for (int i = 1; i <= 7; i++)
      vecs.push_back('{i == 1, 100, i >= 6, K_A, K_B, K_C});
    for (int i = 1; i <= 6; i++)
      vecs.push_back('{i == 1, -1, i == 6, N_A, N_B, N_C});

    do_reset();
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_data", longint'($signed(out_data)), 0);
    chk("rst_phase", longint'(out_phase), 0);
    chk("rst_ready", longint'(in_ready), 1);

    foreach (vecs[k]) begin
      if (vecs[k].clr) do_reset();
      push_check(vecs[k].din, vecs[k].has_out, vecs[k].ea, vecs[k].eb, vecs[k].ec);
    end

    // Back-pressure during phase B.
    do_reset();
    prime5();
    chk_out("stall_a", R_A, 0);
    @(negedge clock);
    chk_out("stall_b0", R_B, 1);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk_out("stall_hold", R_B, 1);
    end
    out_ready = 1'b1;
    @(negedge clock);
    chk_out("stall_c", R_C, 2);
    @(negedge clock);
    chk("stall_end_valid", longint'(out_valid), 0);

    // Flush during phase A: window must be refilled from scratch.
    do_reset();
    prime5();
    chk_out("flush_a", R_A, 0);
    flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    @(negedge clock);
    chk("flush_valid", longint'(out_valid), 0);
    chk("flush_ready", longint'(in_ready), 1);
    for (int i = 1; i <= 6; i++) push_check(i, i == 6, R_A, R_B, R_C);

    // Reset during EMIT with in_valid asserted: nothing captured.
    do_reset();
    prime5();
    chk_out("rstmid_a", R_A, 0);
    reset = 1'b1; in_valid = 1'b1; in_data = DATA_W'(77);
    @(posedge clock);
    #1 reset = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    chk("rstmid_valid", longint'(out_valid), 0);
    chk("rstmid_data", longint'($signed(out_data)), 0);
    chk("rstmid_phase", longint'(out_phase), 0);
    chk("rstmid_ready", longint'(in_ready), 1);
    for (int i = 1; i <= 6; i++) push_check(i, i == 6, R_A, R_B, R_C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
